// File: rtl/div_share_arbiter.sv
// div_share_arbiter
// Round-robin sequencer that shares one multi-cycle divider among N requesters.
// The winner's operands are latched, the divider is started with a one-cycle
// pulse, and the result returns to the winner with a one-cycle one-hot Ack.
// A zero divisor is answered locally and never reaches the divider.
// Optional build macro DIV_TIMEOUT_EN: bounds the wait for Div_Done to TIMEOUT
// cycles and adds the Timeout_Err output.
module div_share_arbiter #(
   parameter int N       = 4,
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [N-1:0]         Req,
   input  logic [N*WIDTH-1:0]   Dividend_Bus,
   input  logic [N*WIDTH-1:0]   Divisor_Bus,
   output logic [N-1:0]         Ack,
   output logic [WIDTH-1:0]     Quotient_Out,
   output logic [WIDTH-1:0]     Remainder_Out,
   output logic [$clog2(N)-1:0] Id_Out,
   output logic                 Div_By_Zero,
   output logic                 Busy,
   output logic                 Div_Start,
   output logic [WIDTH-1:0]     Div_Dividend,
   output logic [WIDTH-1:0]     Div_Divisor,
   input  logic [WIDTH-1:0]     Div_Quotient,
   input  logic [WIDTH-1:0]     Div_Remainder,
   input  logic                 Div_Done
`ifdef DIV_TIMEOUT_EN
   ,
   output logic                 Timeout_Err
`endif
);

   localparam int IDW = $clog2(N);

   if (N < 2 || N > 8 || WIDTH < 1 || TIMEOUT < 1) begin : g_param_check
      $error("div_share_arbiter: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ZERO,
      S_RESPOND
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   sel_q, sel_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             start_q, start_d;
   logic [N-1:0]     ack_q, ack_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [IDW-1:0]   ido_q, ido_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q;
   logic             done_rise;

`ifdef DIV_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             terr_q, terr_d;
`endif

   logic             grant_vld;
   logic [IDW-1:0]   grant_id;
   logic [WIDTH-1:0] grant_dvd;
   logic [WIDTH-1:0] grant_dvs;
   logic [31:0]      ptr_ext;
   logic [IDW-1:0]   ptr_next;

   assign ptr_ext   = 32'(ptr_q);
   assign done_rise = Div_Done & ~done_q;
   assign ptr_next  = (sel_q == IDW'(N - 1)) ? '0 : sel_q + IDW'(1);

   // Round-robin pick: first request at/above the pointer, then wrap below it.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      grant_dvd = '0;
      grant_dvs = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!grant_vld && Req[i] && i >= ptr_ext) begin
            grant_vld = 1'b1;
            grant_id  = IDW'(i);
            grant_dvd = Dividend_Bus[i*WIDTH +: WIDTH];
            grant_dvs = Divisor_Bus[i*WIDTH +: WIDTH];
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!grant_vld && Req[i] && i < ptr_ext) begin
            grant_vld = 1'b1;
            grant_id  = IDW'(i);
            grant_dvd = Dividend_Bus[i*WIDTH +: WIDTH];
            grant_dvs = Divisor_Bus[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      start_d = 1'b0;
      ack_d   = '0;
      quo_d   = quo_q;
      rem_d   = rem_q;
      ido_d   = ido_q;
      dbz_d   = 1'b0;
`ifdef DIV_TIMEOUT_EN
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               sel_d = grant_id;
               dvd_d = grant_dvd;
               dvs_d = grant_dvs;
               if (grant_dvs == '0) begin
                  state_d = S_ZERO;
               end else begin
                  state_d = S_ISSUE;
                  start_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef DIV_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (done_rise) begin
               quo_d        = Div_Quotient;
               rem_d        = Div_Remainder;
               ido_d        = sel_q;
               ack_d[sel_q] = 1'b1;
               state_d      = S_RESPOND;
            end
`ifdef DIV_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               quo_d        = '0;
               rem_d        = '0;
               terr_d       = 1'b1;
               ido_d        = sel_q;
               ack_d[sel_q] = 1'b1;
               state_d      = S_RESPOND;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         S_ZERO: begin
            quo_d        = '1;
            rem_d        = dvd_q;
            dbz_d        = 1'b1;
            ido_d        = sel_q;
            ack_d[sel_q] = 1'b1;
            state_d      = S_RESPOND;
         end
         S_RESPOND: begin
            ptr_d   = ptr_next;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         start_q <= 1'b0;
         ack_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         ido_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIV_TIMEOUT_EN
         cnt_q   <= '0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         start_q <= start_d;
         ack_q   <= ack_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         ido_q   <= ido_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= Div_Done;
`ifdef DIV_TIMEOUT_EN
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
`endif
      end
   end

   assign Ack           = ack_q;
   assign Quotient_Out  = quo_q;
   assign Remainder_Out = rem_q;
   assign Id_Out        = ido_q;
   assign Div_By_Zero   = dbz_q;
   assign Busy          = busy_q;
   assign Div_Start     = start_q;
   assign Div_Dividend  = dvd_q;
   assign Div_Divisor   = dvs_q;
`ifdef DIV_TIMEOUT_EN
   assign Timeout_Err   = terr_q;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter
// Scoreboarded bench: requesters drain per-requester operand lists, a
// behavioural divider answers Div_Start with random latency and level/pulse
// Done, and a round-robin service model predicts every Ack.
// Define DIV_TIMEOUT_EN to also exercise the divider timeout.
module tb_div_share_arbiter;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int TMO = 64;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      logic         terr;
   } exp_t;

   logic           Clock = 1'b0;
   logic           Reset = 1'b0;
   logic [N-1:0]   Req;
   logic [N*W-1:0] Dividend_Bus;
   logic [N*W-1:0] Divisor_Bus;
   logic [N-1:0]   Ack;
   logic [W-1:0]   Quotient_Out;
   logic [W-1:0]   Remainder_Out;
   logic [1:0]     Id_Out;
   logic           Div_By_Zero;
   logic           Busy;
   logic           Div_Start;
   logic [W-1:0]   Div_Dividend;
   logic [W-1:0]   Div_Divisor;
   logic [W-1:0]   Div_Quotient;
   logic [W-1:0]   Div_Remainder;
   logic           Div_Done;
`ifdef DIV_TIMEOUT_EN
   logic           Timeout_Err;
`endif

   div_share_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .Req           (Req),
      .Dividend_Bus  (Dividend_Bus),
      .Divisor_Bus   (Divisor_Bus),
      .Ack           (Ack),
      .Quotient_Out  (Quotient_Out),
      .Remainder_Out (Remainder_Out),
      .Id_Out        (Id_Out),
      .Div_By_Zero   (Div_By_Zero),
      .Busy          (Busy),
      .Div_Start     (Div_Start),
      .Div_Dividend  (Div_Dividend),
      .Div_Divisor   (Div_Divisor),
      .Div_Quotient  (Div_Quotient),
      .Div_Remainder (Div_Remainder),
      .Div_Done      (Div_Done)
`ifdef DIV_TIMEOUT_EN
      ,
      .Timeout_Err   (Timeout_Err)
`endif
   );

   always #5 Clock = ~Clock;

   int unsigned cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int          errors = 0;
   int          checks = 0;
   exp_t        exp_q[$];
   op_t         ops [N][16];
   int unsigned head [N];
   int unsigned cnt [N];
   int unsigned model_ptr = 0;
   int unsigned start_seen = 0;
   int unsigned start_exp = 0;
   bit          div_hang = 1'b0;
   int unsigned fixed_lat = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Requesters: each presents the head of its operand list and advances on Ack.
   initial begin
      Req = '0;
      Dividend_Bus = '0;
      Divisor_Bus = '0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         cnt[i] = 0;
      end
      forever begin
         @(negedge Clock);
         for (int i = 0; i < N; i++) begin
            if (Ack[i] && head[i] < cnt[i]) head[i]++;
            Req[i] = (head[i] < cnt[i]);
            if (head[i] < cnt[i]) begin
               Dividend_Bus[i*W +: W] = ops[i][head[i]].a;
               Divisor_Bus[i*W +: W]  = ops[i][head[i]].b;
            end
         end
      end
   end

   // Behavioural divider: random latency, Done either held (level) or pulsed.
   logic [W-1:0] dv_a, dv_b;
   int unsigned  dv_lat;
   bit           dv_pulse;
   initial begin
      Div_Done = 1'b0;
      Div_Quotient = '0;
      Div_Remainder = '0;
      forever begin
         @(negedge Clock);
         if (Div_Start) begin
            dv_a = Div_Dividend;
            dv_b = Div_Divisor;
            dv_lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 5);
            dv_pulse = 1'($urandom_range(0, 1));
            @(posedge Clock);
            #1 Div_Done = 1'b0;
            if (!div_hang) begin
               repeat (dv_lat) @(posedge Clock);
               #1;
               Div_Quotient  = (dv_b == 0) ? '1 : dv_a / dv_b;
               Div_Remainder = (dv_b == 0) ? dv_a : dv_a % dv_b;
               Div_Done = 1'b1;
               if (dv_pulse) begin
                  @(posedge Clock);
                  #1 Div_Done = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every Ack and checks protocol timing.
   exp_t        e;
   logic        prev_start = 1'b0, prev_done = 1'b0, prev_busy = 1'b0, ack_prev = 1'b0;
   int unsigned rise_cyc = 0, start_cyc = 0, busy_rise_cyc = 0;
   initial begin
      forever begin
         @(negedge Clock);
         if (Div_Done && !prev_done) rise_cyc = cyc;
         prev_done = Div_Done;
         if (Busy && !prev_busy) busy_rise_cyc = cyc;
         prev_busy = Busy;
         if (Div_Start) begin
            check("start_single_cycle", 32'(prev_start), 0);
            check("start_at_grant", cyc - busy_rise_cyc, 0);
            start_seen++;
            start_cyc = cyc;
         end
         prev_start = Div_Start;
         if (ack_prev) check("idle_after_ack", 32'(Busy), 0);
         ack_prev = (Ack != '0);
         if (Ack != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 32'(Ack), 0);
            end else begin
               e = exp_q.pop_front();
               check("ack_onehot", 32'(Ack), 32'(1) << e.id);
               check("id_out", 32'(Id_Out), 32'(e.id));
               check("quotient", 32'(Quotient_Out), 32'(e.q));
               check("remainder", 32'(Remainder_Out), 32'(e.r));
               check("div_by_zero", 32'(Div_By_Zero), 32'(e.dbz));
               check("busy_with_ack", 32'(Busy), 1);
`ifdef DIV_TIMEOUT_EN
               check("timeout_err", 32'(Timeout_Err), 32'(e.terr));
`endif
               if (e.terr) check("timeout_latency", cyc - start_cyc, TMO + 1);
               else if (e.dbz) check("zero_latency", cyc - busy_rise_cyc, 1);
               else check("ack_after_done", cyc - rise_cyc, 1);
            end
         end
      end
   end

   task automatic load(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
      ops[i][cnt[i]] = '{a: a, b: b};
      cnt[i]++;
   endtask

   function automatic exp_t expect_for(input int unsigned i, input op_t op);
      exp_t x;
      x.id = 2'(i);
      x.terr = 1'b0;
      if (op.b == 0) begin
         x.q = '1;
         x.r = op.a;
         x.dbz = 1'b1;
      end else begin
         x.q = op.a / op.b;
         x.r = op.a % op.b;
         x.dbz = 1'b0;
      end
      return x;
   endfunction

   // Reference: serve pending lists round-robin from the model pointer.
   task automatic commit_phase();
      int unsigned h [N];
      int unsigned remaining = 0;
      for (int i = 0; i < N; i++) begin
         h[i] = 0;
         remaining += cnt[i];
      end
      while (remaining > 0) begin
         for (int s = 0; s < N; s++) begin
            automatic int unsigned i = (model_ptr + s) % N;
            if (h[i] < cnt[i]) begin
               exp_q.push_back(expect_for(i, ops[i][h[i]]));
               if (ops[i][h[i]].b != 0) start_exp++;
               h[i]++;
               remaining--;
               model_ptr = (i + 1) % N;
               break;
            end
         end
      end
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < N; i++) if (head[i] < cnt[i]) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input int unsigned budget);
      int unsigned n = 0;
      @(negedge Clock);
      #1;
      while ((exp_q.size() != 0 || Busy || pending()) && n < budget) begin
         @(negedge Clock);
         #1;
         n++;
      end
      check("drain_in_budget", 32'(exp_q.size()), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         cnt[i] = 0;
      end
      check("div_start_count", start_seen, start_exp);
      start_seen = 0;
      start_exp = 0;
      repeat (2) @(negedge Clock);
      #1;
   endtask

   task automatic check_reset_state();
      check("rst_ack", 32'(Ack), 0);
      check("rst_busy", 32'(Busy), 0);
      check("rst_start", 32'(Div_Start), 0);
      check("rst_dbz", 32'(Div_By_Zero), 0);
      check("rst_quotient", 32'(Quotient_Out), 0);
      check("rst_remainder", 32'(Remainder_Out), 0);
      check("rst_id", 32'(Id_Out), 0);
      check("rst_div_dividend", 32'(Div_Dividend), 0);
      check("rst_div_divisor", 32'(Div_Divisor), 0);
`ifdef DIV_TIMEOUT_EN
      check("rst_timeout_err", 32'(Timeout_Err), 0);
`endif
   endtask

   task automatic do_reset();
      @(posedge Clock);
      #1 Reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         cnt[i] = 0;
      end
      @(negedge Clock);
      @(negedge Clock);
      check_reset_state();
      @(posedge Clock);
      #1 Reset = 1'b1;
      model_ptr = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   int unsigned n_wait;
   initial begin
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      check_reset_state();
      @(posedge Clock);
      #1 Reset = 1'b1;
      repeat (2) @(negedge Clock);
      #1;

      // Single requester, ordinary divide
      load(0, 100, 3);
      commit_phase();
      drain(100);

      // Two simultaneous requests from pointer 0
      do_reset();
      load(0, 255, 10);
      load(2, 12345, 123);
      commit_phase();
      drain(200);

      // Zero divisor answered locally
      load(1, 255, 0);
      commit_phase();
      drain(100);

      // Four requesters held for eight transactions
      do_reset();
      for (int t = 0; t < 8; t++)
         load(t % 4, (t % 2) ? 16'd32768 : 16'd65535, (t % 2) ? 16'd256 : 16'd255);
      commit_phase();
      drain(600);

      // Reset while waiting on the divider; its late Done must be ignored
      do_reset();
      fixed_lat = 12;
      load(0, 500, 7);
      n_wait = 0;
      while (!Div_Start && n_wait < 20) begin
         @(negedge Clock);
         n_wait++;
      end
      check("abort_start_seen", 32'(Div_Start), 1);
      @(posedge Clock);
      @(posedge Clock);
      #1 Reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         cnt[i] = 0;
      end
      @(posedge Clock);
      #1 Reset = 1'b1;
      model_ptr = 0;
      @(negedge Clock);
      check_reset_state();
      repeat (25) @(negedge Clock);
      #1;
      fixed_lat = 0;
      start_seen = 0;
      load(3, 100, 3);
      commit_phase();
      drain(100);

      // Randomized phases
      for (int p = 0; p < 24; p++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 2) != 0) begin
               automatic int unsigned k = $urandom_range(1, 3);
               for (int j = 0; j < int'(k); j++) begin
                  automatic logic [W-1:0] a = W'($urandom);
                  automatic logic [W-1:0] b;
                  if ($urandom_range(0, 7) == 0) b = '0;
                  else if ($urandom_range(0, 1) == 1) b = W'($urandom_range(1, 15));
                  else b = W'($urandom);
                  load(i, a, b);
               end
            end
         end
         commit_phase();
         drain(1000);
      end

`ifdef DIV_TIMEOUT_EN
      // Divider never completes
      do_reset();
      div_hang = 1'b1;
      load(0, 7, 2);
      exp_q.push_back('{id: 2'd0, q: '0, r: '0, dbz: 1'b0, terr: 1'b1});
      start_exp = 1;
      drain(300);
      div_hang = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
